// File: rtl/mips_abb_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Stop-vector bit k freezes pipeline register k; higher bits are deeper stages.
package mips_abb_pkg;

  typedef logic [5:0] stack_t;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;
  localparam logic RESET  = 1'b1;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} div_state_e;

  // Freeze every stage from pc up to and including 'last'; the spare bit never stops.
  function automatic stack_t stop_upto(int last);
    stack_t s;
    s = {6{NOSTOP}};
    for (int i = STG_PC; i < STG_WB; i++)
      if (i <= last) s[i] = STOP;
    return s;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Handshake bundle between the datapath (master) and the stall controller (slave).
interface stall_ctrl_if;
  import mips_abb_pkg::*;

  logic   id_stallreq;
  logic   exe_i_div;
  logic   div_o_done;
  logic   div_i_start;
  logic   div_i_annul;
  logic   div_res_valid;
  logic   mem_i_req;
  logic   dram_ack;
  logic   flush_req;
  logic   flush;
  stack_t stop;
  logic   wdog_err;

  modport master (
    output id_stallreq, exe_i_div, div_o_done, mem_i_req, dram_ack, flush_req,
    input  div_i_start, div_i_annul, div_res_valid, flush, stop, wdog_err
  );

  modport slave (
    input  id_stallreq, exe_i_div, div_o_done, mem_i_req, dram_ack, flush_req,
    output div_i_start, div_i_annul, div_res_valid, flush, stop, wdog_err
  );
endinterface

// File: rtl/stall_wdog.sv
// Saturating wait counter; tmo is high once LIMIT cycles have been counted.
module stall_wdog
  import mips_abb_pkg::*;
#(
  parameter int LIMIT = 15,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tmo
);

  logic [W-1:0] cnt;

  assign tmo = (cnt == W'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst == RESET)    cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !tmo) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: merges ID/EXE/MEM stall requests into the stop
// vector, sequences the multi-cycle divider and bounds divider and DRAM waits.
module stall_ctrl
  import mips_abb_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int MEM_TIMEOUT = 15
) (
  input logic          cpu_clk,
  input logic          cpu_rst_n,
  stall_ctrl_if.slave  sc
);

  div_state_e state, state_nx;
  stack_t     stop_v;
  logic       div_stall, div_tmo, div_fire;
  logic       mem_stall, mem_tmo;
  logic       err_q;

  // Divider watchdog counts D_BUSY cycles; saturating at DIV_TIMEOUT-1 marks the last allowed one.
  stall_wdog #(.LIMIT(DIV_TIMEOUT - 1)) u_div_wdog (
    .clk (cpu_clk),
    .rst (cpu_rst_n),
    .clr (state != D_BUSY || sc.flush_req),
    .inc (state == D_BUSY),
    .tmo (div_tmo)
  );

  stall_wdog #(.LIMIT(MEM_TIMEOUT)) u_mem_wdog (
    .clk (cpu_clk),
    .rst (cpu_rst_n),
    .clr (sc.flush_req || sc.dram_ack || !sc.mem_i_req),
    .inc (mem_stall),
    .tmo (mem_tmo)
  );

  assign mem_stall = sc.mem_i_req && !sc.dram_ack && !mem_tmo;
  assign div_stall = !sc.flush_req &&
                     ((state == D_IDLE && sc.exe_i_div) || state == D_BUSY);

  // Deepest requester wins; flush overrides every stall.
  always_comb begin
    stop_v = {6{NOSTOP}};
    if (!sc.flush_req) begin
      if (mem_stall)           stop_v = stop_upto(STG_MEM);
      else if (div_stall)      stop_v = stop_upto(STG_EX);
      else if (sc.id_stallreq) stop_v = stop_upto(STG_ID);
    end
  end

  assign sc.stop     = stop_v;
  assign sc.flush    = sc.flush_req;
  // mem_tmo is folded in directly so the error is visible in the release cycle.
  assign sc.wdog_err = err_q || mem_tmo;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst_n == RESET) begin
      state <= D_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_q || div_fire || mem_tmo;
    end
  end

  always_comb begin
    state_nx         = state;
    div_fire         = 1'b0;
    sc.div_i_start   = 1'b0;
    sc.div_i_annul   = 1'b0;
    sc.div_res_valid = 1'b0;
    unique case (state)
      D_IDLE: if (sc.exe_i_div && !sc.flush_req) begin
        sc.div_i_start = 1'b1;
        state_nx       = D_BUSY;
      end
      D_BUSY: begin
        if (sc.flush_req) begin
          sc.div_i_annul = 1'b1;
          state_nx       = D_IDLE;
        end else if (sc.div_o_done) begin
          state_nx = D_DONE;
        end else if (div_tmo) begin
          div_fire       = 1'b1;
          sc.div_i_annul = 1'b1;
          state_nx       = D_DONE;
        end
      end
      // Hold the result until exemem actually captures it, so the same divide is never relaunched.
      D_DONE: begin
        sc.div_res_valid = 1'b1;
        if (sc.flush_req || stop_v[STG_EX] == NOSTOP) state_nx = D_IDLE;
      end
      default: state_nx = D_IDLE;
    endcase
  end

endmodule
